// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher with a DEPTH-entry pc/inst queue and single-cycle redirect flush; `IFU_STAT_EN adds fetch_cnt/flush_cnt
module ifu_prefetch #(
  parameter int XLEN = 64,
  parameter int IW = 32,
  parameter int AW = 11,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  output logic            imem_en,
  output logic [AW-1:0]   imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [IW-1:0]   inst
`ifdef IFU_STAT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_pc_q [DEPTH];
  logic [IW-1:0]   r_in_q [DEPTH];
  logic [CW-1:0]   w_occ;
  logic            w_issue;
  logic            w_wr;
  logic            w_rd;
  // The in-flight request holds a reserved slot, so occupancy counts it.
  assign w_occ = r_count + CW'(r_inflight);
  // Reset gates the enable so the ROM sees no read while reset is held.
  assign w_issue = !sys_rst && !redirect_valid && (w_occ < CW'(DEPTH));
  assign w_wr = r_inflight && !redirect_valid;
  assign w_rd = inst_valid && inst_ready;
  assign imem_en = w_issue;
  assign imem_addr = r_fetch_pc[AW+1:2];
  assign inst_valid = r_count != '0;
  assign inst_pc = r_pc_q[r_rd_ptr];
  assign inst = r_in_q[r_rd_ptr];
  // Fetch PC, in-flight tracking and queue; redirect empties everything and kills the pending response.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc <= '0;
      r_inflight <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i] <= '0;
        r_in_q[i] <= '0;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_req_pc <= r_fetch_pc;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count <= '0;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_wr) begin
          r_pc_q[r_wr_ptr] <= r_req_pc;
          r_in_q[r_wr_ptr] <= imem_rdata;
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
    end
  end
`ifdef IFU_STAT_EN
  logic w_flush;
  // A redirect flushes something if a response is pending or entries remain beyond the one being dequeued.
  assign w_flush = redirect_valid && (r_inflight || (r_count > CW'(w_rd)));
  // Statistics counters, wrapping at 2^32.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(w_wr);
      flush_cnt <= flush_cnt + 32'(w_flush);
    end
  end
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed and random checks of ifu_prefetch against an in-order delivery model
module tb_ifu_prefetch;
  localparam int XLEN = 64;
  localparam int IW = 32;
  localparam int AW = 11;
  localparam int DEPTH = 4;
  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            imem_en;
  logic [AW-1:0]   imem_addr;
  logic [IW-1:0]   imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [XLEN-1:0] inst_pc;
  logic [IW-1:0]   inst;
`ifdef IFU_STAT_EN
  logic [31:0]     fetch_cnt;
  logic [31:0]     flush_cnt;
`endif
  int checks = 0;
  int failures = 0;
  int issues = 0;
  int deliv = 0;
  int occ = 0;
  int first_en;
  int first_val;
  logic [63:0] exp_pc = '0;
  logic prev_rv = 1'b0;
  logic last_en = 1'b0;
  logic cur_en;
  logic cur_val;

  ifu_prefetch #(.XLEN(XLEN), .IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_pc(inst_pc),
    .inst(inst)
`ifdef IFU_STAT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    return 32'h1000 + 32'(a);
  endfunction

  always @(posedge sys_clk) if (imem_en) imem_rdata <= rom(imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [63:0] rpc);
    inst_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    cur_en = imem_en;
    cur_val = inst_valid;
    if (prev_rv) chk("flush_valid", inst_valid, 0);
    if (rv) chk("no_issue_on_redirect", imem_en, 0);
    if (imem_en) begin
      issues++;
      occ++;
    end
    if (inst_valid && rdy) begin
      chk("pc", inst_pc, exp_pc);
      chk("inst", inst, rom(exp_pc[AW+1:2]));
      exp_pc += 64'd4;
      deliv++;
      occ--;
    end
    chk("occ_le_depth", occ <= DEPTH, 1);
    if (rv) begin
      exp_pc = {rpc[63:2], 2'b00};
      occ = 0;
    end
    prev_rv = rv;
    last_en = imem_en;
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_pc = '0;
    occ = 0;
    issues = 0;
    deliv = 0;
    prev_rv = 1'b0;
    last_en = 1'b0;
  endtask

  initial begin
    @(negedge sys_clk);
    chk("rst_valid", inst_valid, 0);
    chk("rst_en", imem_en, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_inst", inst, 0);
    do_reset();
    first_en = -1;
    first_val = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, '0);
      if (cur_en && first_en < 0) first_en = i;
      if (cur_val && first_val < 0) first_val = i;
    end
    chk("latency", 64'(first_val - first_en), 2);
    chk("stream_deliv", deliv, 6);
    do_reset();
    repeat (10) cycle(1'b0, 1'b0, '0);
    chk("full_issues", issues, 4);
    chk("full_en", imem_en, 0);
    chk("full_valid", inst_valid, 1);
    repeat (8) cycle(1'b1, 1'b0, '0);
    chk("drain_deliv", deliv, 8);
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 64'h83);
    deliv = 0;
    repeat (5) cycle(1'b1, 1'b0, '0);
    chk("redir_deliv", deliv, 3);
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 64'h200);
    chk("deq_redir_deliv", deliv, 2);
    deliv = 0;
    repeat (5) cycle(1'b1, 1'b0, '0);
    chk("after_deq_redir", deliv, 3);
    do_reset();
    repeat (6) cycle(1'b1, 1'b0, '0);
    chk("pre_rst_valid", inst_valid, 1);
    #3 sys_rst = 1'b1;
    #1;
    chk("async_rst_valid", inst_valid, 0);
    chk("async_rst_en", imem_en, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_pc = '0;
    occ = 0;
    prev_rv = 1'b0;
    deliv = 0;
    repeat (5) cycle(1'b1, 1'b0, '0);
    chk("post_rst_deliv", deliv, 3);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [63:0] rpc;
      rpc = {$urandom, $urandom};
      if ($urandom % 4 == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
      cycle($urandom % 4 != 0, $urandom % 20 == 0, rpc);
    end
    chk("rand_deliv_min", deliv > 300, 1);
`ifdef IFU_STAT_EN
    begin
      logic killed;
      int guard;
      do_reset();
      chk("fc_rst", fetch_cnt, 0);
      chk("flc_rst", flush_cnt, 0);
      guard = 0;
      while (deliv < 10 && guard < 50) begin
        cycle(1'b1, 1'b0, '0);
        guard++;
      end
      chk("stat_deliv", deliv, 10);
      killed = last_en;
      cycle(1'b1, 1'b1, 64'h400);
      cycle(1'b1, 1'b1, 64'h800);
      chk("fetch_cnt", fetch_cnt, 64'(issues - int'(killed)));
      chk("flush_cnt", flush_cnt, 1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
